serial_full_subtractor: RTL and testbench

//  Multi-cycle bit-serial subtractor: the inverse operation of the one-bit full adder.

---
 rtl/serial_full_subtractor_if.sv | 25 ++
 rtl/serial_full_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_full_subtractor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_full_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             bin;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start_valid, lhs, rhs, bin, done_ready,
        input  start_ready, done_valid, diff, bout
    );

    modport slave (
        input  start_valid, lhs, rhs, bin, done_ready,
        output start_ready, done_valid, diff, bout
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = lhs - rhs - bin, one bit per cycle LSB first,
// built from a single one-bit full-subtractor cell and a registered borrow.
//
// state  | meaning
// S_IDLE | waiting for operands (start_ready once out of reset)
// S_RUN  | one result bit per edge, WIDTH edges total
// S_DONE | result held until the consumer takes it
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_full_subtractor_if.slave s_if
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_armed;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_start_ready;
    logic             w_done_valid;
    logic             w_accept;
    logic             w_release;
    logic             w_d;
    logic             w_borrow_nxt;
    logic [WIDTH:0]   w_diff_ext;

    // r_armed keeps start_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_ready = 1'b0;
        w_done_valid  = 1'b0;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_ready = r_armed;
                if (s_if.start_valid && r_armed) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_valid = 1'b1;
                if (s_if.done_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    // Prepending the new bit and dropping the LSB also covers WIDTH=1
    assign w_diff_ext   = {w_d, r_diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= s_if.lhs;
            r_b      <= s_if.rhs;
            r_borrow <= s_if.bin;
            r_diff   <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrow_nxt;
            r_diff   <= w_diff_ext[WIDTH:1];
            r_cnt    <= r_cnt + 1'b1;
        end else if (w_release) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign s_if.start_ready = w_start_ready;
    assign s_if.done_valid  = w_done_valid;
    assign s_if.diff        = (r_state == S_DONE) ? r_diff : '0;
    assign s_if.bout        = (r_state == S_DONE) ? r_borrow : 1'b0;
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor at WIDTH 8, 4 and 1 against an arithmetic
// reference (plain integer subtraction with wrap and sign test).
module tb_serial_full_subtractor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_full_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_full_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_full_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_full_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .s_if(bus8));
    serial_full_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .s_if(bus4));
    serial_full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .s_if(bus1));

    function automatic logic [31:0] exp_diff(int w, longint a, longint b, longint bi);
        longint r;
        longint m;
        r = a - b - bi;
        m = longint'(1) << w;
        return 32'(((r % m) + m) % m);
    endfunction

    function automatic logic exp_bout(longint a, longint b, longint bi);
        return (a < b + bi);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with the WIDTH=8 DUT idle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input bit noisy, input bit early_ready, input int bp);
        int         lat;
        logic [7:0] ed;
        logic       eb;
        ed = 8'(exp_diff(8, longint'(a), longint'(b), longint'(bi)));
        eb = exp_bout(longint'(a), longint'(b), longint'(bi));
        check("op8_start_ready", 64'(bus8.start_ready), 64'(1));
        bus8.lhs         = a;
        bus8.rhs         = b;
        bus8.bin         = bi;
        bus8.start_valid = 1'b1;
        bus8.done_ready  = early_ready;
        @(negedge clk);
        if (!noisy) bus8.start_valid = 1'b0;
        bus8.lhs = 8'($urandom);
        bus8.rhs = 8'($urandom);
        bus8.bin = 1'($urandom);
        check("op8_busy_ready", 64'(bus8.start_ready), 64'(0));
        lat = 0;
        while (bus8.done_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            bus8.lhs = 8'($urandom);
            bus8.rhs = 8'($urandom);
        end
        bus8.start_valid = 1'b0;
        check("op8_latency", 64'(lat), 64'(8));
        check("op8_diff", 64'(bus8.diff), 64'(ed));
        check("op8_bout", 64'(bus8.bout), 64'(eb));
        for (int i = 0; i < bp; i++) begin
            bus8.start_valid = 1'b1;
            bus8.lhs = 8'($urandom);
            bus8.rhs = 8'($urandom);
            bus8.bin = 1'($urandom);
            @(negedge clk);
            check("bp_done_valid", 64'(bus8.done_valid), 64'(1));
            check("bp_diff", 64'(bus8.diff), 64'(ed));
            check("bp_bout", 64'(bus8.bout), 64'(eb));
            check("bp_start_ready", 64'(bus8.start_ready), 64'(0));
        end
        bus8.start_valid = 1'b0;
        bus8.done_ready  = 1'b1;
        @(negedge clk);
        bus8.done_ready = 1'b0;
        check("op8_post_done_valid", 64'(bus8.done_valid), 64'(0));
        check("op8_post_start_ready", 64'(bus8.start_ready), 64'(1));
        check("op8_post_diff", 64'(bus8.diff), 64'(0));
        check("op8_post_bout", 64'(bus8.bout), 64'(0));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        int lat;
        bus4.lhs         = a;
        bus4.rhs         = b;
        bus4.bin         = bi;
        bus4.start_valid = 1'b1;
        @(negedge clk);
        bus4.start_valid = 1'b0;
        lat = 0;
        while (bus4.done_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("op4_latency", 64'(lat), 64'(4));
        check("op4_diff", 64'(bus4.diff), 64'(exp_diff(4, longint'(a), longint'(b), longint'(bi))));
        check("op4_bout", 64'(bus4.bout), 64'(exp_bout(longint'(a), longint'(b), longint'(bi))));
        bus4.done_ready = 1'b1;
        @(negedge clk);
        bus4.done_ready = 1'b0;
        check("op4_post_ready", 64'(bus4.start_ready), 64'(1));
    endtask

    task automatic op1(input logic a, input logic b, input logic bi);
        int lat;
        bus1.lhs         = a;
        bus1.rhs         = b;
        bus1.bin         = bi;
        bus1.start_valid = 1'b1;
        @(negedge clk);
        bus1.start_valid = 1'b0;
        lat = 0;
        while (bus1.done_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("op1_latency", 64'(lat), 64'(1));
        check("op1_diff", 64'(bus1.diff), 64'(exp_diff(1, longint'(a), longint'(b), longint'(bi))));
        check("op1_bout", 64'(bus1.bout), 64'(exp_bout(longint'(a), longint'(b), longint'(bi))));
        bus1.done_ready = 1'b1;
        @(negedge clk);
        bus1.done_ready = 1'b0;
        check("op1_post_ready", 64'(bus1.start_ready), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.start_valid = 1'b0; bus8.lhs = '0; bus8.rhs = '0; bus8.bin = 1'b0; bus8.done_ready = 1'b0;
        bus4.start_valid = 1'b0; bus4.lhs = '0; bus4.rhs = '0; bus4.bin = 1'b0; bus4.done_ready = 1'b0;
        bus1.start_valid = 1'b0; bus1.lhs = '0; bus1.rhs = '0; bus1.bin = 1'b0; bus1.done_ready = 1'b0;

        #7;
        check("rst_start_ready", 64'(bus8.start_ready), 64'(0));
        check("rst_done_valid", 64'(bus8.done_valid), 64'(0));
        check("rst_diff", 64'(bus8.diff), 64'(0));
        check("rst_bout", 64'(bus8.bout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arm_ready8", 64'(bus8.start_ready), 64'(1));
        check("arm_ready4", 64'(bus4.start_ready), 64'(1));
        check("arm_ready1", 64'(bus1.start_ready), 64'(1));

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
        op8(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        op8(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 0);
        op8(8'hC3, 8'h4D, 1'b1, 1'b1, 1'b0, 5);

        for (int i = 0; i < 24; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), i[0], (i % 3) == 1, 0);
        end

        // Abort after the third RUN edge
        bus8.lhs = 8'hA7; bus8.rhs = 8'h19; bus8.bin = 1'b0;
        bus8.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_done_valid", 64'(bus8.done_valid), 64'(0));
        check("abort_diff", 64'(bus8.diff), 64'(0));
        check("abort_bout", 64'(bus8.bout), 64'(0));
        check("abort_start_ready", 64'(bus8.start_ready), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rearm_ready", 64'(bus8.start_ready), 64'(1));
        op8(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    op4(4'(a), 4'(b), 1'(bi));
                end
            end
        end

        op1(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
